apb_regfile_slave: RTL and testbench

APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

---
 rtl/apb_regfile_slave.sv | 144 ++++++++++++++
 tb/tb_apb_regfile_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// APB register-file slave: NUM_REGS data registers, wait-state config, ID.
// Wait states come from WAIT_CFG and are captured when each transfer starts.
module apb_regfile_slave #(
   parameter int         PADDR_SIZE = 6,
   parameter int         PDATA_SIZE = 8,
   parameter int         NUM_REGS   = 8,
   parameter logic [7:0] ID_VALUE   = 8'hA5
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [2:0]              PPROT,
   input  logic [PADDR_SIZE-1:0]   PADDR,
   input  logic [PDATA_SIZE-1:0]   PWDATA,
   input  logic [PDATA_SIZE/8-1:0] PSTRB,
   output logic [PDATA_SIZE-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int          NB     = PDATA_SIZE / 8;
   localparam logic [31:0] A_WCFG = 32'(NUM_REGS);
   localparam logic [31:0] A_ID   = 32'(NUM_REGS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_t;

   state_t                r_state;
   logic [3:0]            r_cnt;
   logic                  r_miss;
   logic [3:0]            r_wcfg;
   logic [PDATA_SIZE-1:0] r_data [NUM_REGS];

   logic [31:0]           w_addr;
   logic                  w_done;
   logic                  w_is_data;
   logic                  w_is_wcfg;
   logic                  w_is_id;
   logic                  w_err;
   logic                  w_wr_en;
   logic [PDATA_SIZE-1:0] w_rd;
   logic [PDATA_SIZE-1:0] w_wmask;
   logic                  w_unused;

   assign w_addr    = 32'(PADDR);
   assign w_is_data = (w_addr < A_WCFG);
   assign w_is_wcfg = (w_addr == A_WCFG);
   assign w_is_id   = (w_addr == A_ID);
   assign w_unused  = ^PPROT[2:1];

   // Completion is the only cycle in which the slave drives anything.
   assign w_done  = (r_state == S_ACCESS) && (r_cnt == 4'd0) && !PRESET;
   assign w_wr_en = w_done && PWRITE && !w_err;

   always_comb begin
      w_err = 1'b0;
      if (r_miss)
         w_err = 1'b1;
      else if (PWRITE)
         w_err = !(w_is_data || (w_is_wcfg && PPROT[0]));
      else
         w_err = !(w_is_data || w_is_wcfg || w_is_id);
   end

   always_comb begin
      w_rd = '0;
      if (w_is_wcfg)
         w_rd = PDATA_SIZE'(r_wcfg);
      if (w_is_id)
         w_rd = PDATA_SIZE'(ID_VALUE);
      for (int i = 0; i < NUM_REGS; i++)
         if (w_addr == 32'(i))
            w_rd = r_data[i];
   end

   always_comb begin
      w_wmask = '0;
      for (int b = 0; b < NB; b++)
         w_wmask[b*8 +: 8] = {8{PSTRB[b]}};
   end

   assign PREADY  = w_done;
   assign PSLVERR = w_done && w_err;
   assign PRDATA  = (w_done && !PWRITE && !w_err) ? w_rd : '0;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_miss  <= 1'b0;
         r_wcfg  <= 4'd0;
         for (int i = 0; i < NUM_REGS; i++)
            r_data[i] <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (PSEL && !PENABLE) begin
                  r_state <= S_SETUP;
                  r_cnt   <= r_wcfg;
                  r_miss  <= 1'b0;
               end else if (PSEL && PENABLE) begin
                  // Missing setup phase: complete at once with an error.
                  r_state <= S_ACCESS;
                  r_cnt   <= 4'd0;
                  r_miss  <= 1'b1;
               end
            end
            S_SETUP: begin
               if (!PSEL)
                  r_state <= S_IDLE;
               else if (PENABLE)
                  r_state <= S_ACCESS;
               else
                  r_cnt <= r_wcfg;
            end
            S_ACCESS: begin
               if (r_cnt == 4'd0)
                  r_state <= S_IDLE;
               else if (!PSEL)
                  r_state <= S_IDLE;
               else
                  r_cnt <= r_cnt - 4'd1;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_wr_en) begin
            for (int i = 0; i < NUM_REGS; i++)
               if (w_addr == 32'(i))
                  r_data[i] <= (r_data[i] & ~w_wmask)
                             | (PWDATA & w_wmask);
            if (w_is_wcfg)
               r_wcfg <= (r_wcfg & ~w_wmask[3:0])
                       | (PWDATA[3:0] & w_wmask[3:0]);
         end
      end
   end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave (32-bit data, 8 registers).
// Stimulus queues expected responses; a negedge monitor checks completions.
module tb_apb_regfile_slave;

   logic        clk = 1'b0;
   logic        PRESET;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [2:0]  PPROT;
   logic [5:0]  PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int checks   = 0;
   int failures = 0;
   int en_cnt   = 0;

   typedef struct {
      string       name;
      bit          is_read;
      logic [31:0] rdata;
      bit          err;
      int          cycles;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   apb_regfile_slave #(
      .PADDR_SIZE(6),
      .PDATA_SIZE(32),
      .NUM_REGS  (8),
      .ID_VALUE  (8'hA5)
   ) dut (
      .PCLK   (clk),
      .PRESET (PRESET),
      .PSEL   (PSEL),
      .PENABLE(PENABLE),
      .PWRITE (PWRITE),
      .PPROT  (PPROT),
      .PADDR  (PADDR),
      .PWDATA (PWDATA),
      .PSTRB  (PSTRB),
      .PRDATA (PRDATA),
      .PREADY (PREADY),
      .PSLVERR(PSLVERR)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: enable-cycle count covers setup state plus access cycles.
   always @(negedge clk) begin
      exp_t e;
      if (PSEL && PENABLE)
         en_cnt++;
      else
         en_cnt = 0;
      if (!PREADY) begin
         chk("idle_prdata", PRDATA, 32'h0);
         chk("idle_pslverr", {31'h0, PSLVERR}, 32'h0);
      end else begin
         if (sb.size() == 0) begin
            chk("unexpected_pready", 32'h1, 32'h0);
         end else begin
            e = sb.pop_front();
            chk({e.name, ".latency"}, en_cnt, e.cycles);
            chk({e.name, ".pslverr"}, {31'h0, PSLVERR}, {31'h0, e.err});
            if (e.is_read)
               chk({e.name, ".prdata"}, PRDATA, e.rdata);
         end
         en_cnt = 0;
      end
   end

   task automatic xfer(input string nm, input bit wr,
                       input logic [5:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p,
                       input logic [31:0] exp_rd, input bit exp_err,
                       input int cyc, input bit miss);
      exp_t e;
      bit   done;
      e.name    = nm;
      e.is_read = !wr;
      e.rdata   = exp_rd;
      e.err     = exp_err;
      e.cycles  = cyc;
      sb.push_back(e);
      @(posedge clk) #1;
      PSEL    = 1'b1;
      PENABLE = miss;
      PWRITE  = wr;
      PADDR   = a;
      PWDATA  = d;
      PSTRB   = s;
      PPROT   = p;
      if (!miss) begin
         @(posedge clk) #1;
         PENABLE = 1'b1;
      end
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (PREADY)
            done = 1'b1;
      end
      if (!done) begin
         chk({nm, ".timeout"}, 32'h0, 32'h1);
         if (sb.size() != 0)
            void'(sb.pop_back());
      end
      @(posedge clk) #1;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
   endtask

   task automatic wr(input string nm, input logic [5:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [2:0] p, input bit err, input int cyc);
      xfer(nm, 1'b1, a, d, s, p, 32'h0, err, cyc, 1'b0);
   endtask

   task automatic rd(input string nm, input logic [5:0] a,
                     input logic [31:0] exp, input bit err, input int cyc);
      xfer(nm, 1'b0, a, 32'h0, 4'h0, 3'b000, exp, err, cyc, 1'b0);
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, ".pready"}, {31'h0, PREADY}, 32'h0);
      chk({nm, ".pslverr"}, {31'h0, PSLVERR}, 32'h0);
      chk({nm, ".prdata"}, PRDATA, 32'h0);
   endtask

   initial begin
      PRESET  = 1'b1;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PPROT   = 3'b000;
      PADDR   = '0;
      PWDATA  = '0;
      PSTRB   = '0;
      repeat (3) begin
         @(negedge clk);
         chk_quiet("reset");
      end
      @(posedge clk) #1;
      PRESET = 1'b0;

      // Reset contents; WAIT_CFG=0 gives two enable cycles.
      rd("rst_data0", 6'd0, 32'h0, 1'b0, 2);
      rd("rst_wcfg", 6'd8, 32'h0, 1'b0, 2);
      rd("rst_id", 6'd9, 32'h0000_00A5, 1'b0, 2);

      wr("w_d3", 6'd3, 32'h0000_005C, 4'b0001, 3'b000, 1'b0, 2);
      rd("r_d3", 6'd3, 32'h0000_005C, 1'b0, 2);

      wr("w_d1_full", 6'd1, 32'h1122_3344, 4'b1111, 3'b000, 1'b0, 2);
      wr("w_d1_strb", 6'd1, 32'hAABB_CCDD, 4'b0101, 3'b000, 1'b0, 2);
      rd("r_d1", 6'd1, 32'h11BB_33DD, 1'b0, 2);

      // Error cases leave state untouched.
      wr("w_id", 6'd9, 32'h1234_5678, 4'hF, 3'b001, 1'b1, 2);
      wr("w_unmap", 6'h3F, 32'h1234_5678, 4'hF, 3'b001, 1'b1, 2);
      rd("r_unmap", 6'h3F, 32'h0, 1'b1, 2);
      wr("w_wcfg_np", 6'd8, 32'h0000_0007, 4'hF, 3'b000, 1'b1, 2);
      rd("r_id", 6'd9, 32'h0000_00A5, 1'b0, 2);
      rd("r_wcfg_np", 6'd8, 32'h0, 1'b0, 2);

      xfer("w_miss", 1'b1, 6'd0, 32'hDEAD_BEEF, 4'hF, 3'b001,
           32'h0, 1'b1, 2, 1'b1);
      rd("r_d0_miss", 6'd0, 32'h0, 1'b0, 2);

      // WAIT_CFG=3: five enable cycles from the next transfer on.
      wr("w_wcfg3", 6'd8, 32'h0000_00A3, 4'hF, 3'b001, 1'b0, 2);
      rd("r_d0_w3", 6'd0, 32'h0, 1'b0, 5);
      rd("r_wcfg3", 6'd8, 32'h0000_0003, 1'b0, 5);
      wr("w_d7", 6'd7, 32'h1234_5678, 4'hF, 3'b000, 1'b0, 5);
      rd("r_d7", 6'd7, 32'h1234_5678, 1'b0, 5);

      // Abort: PSEL dropped in the first access cycle.
      wr("w_wcfg2", 6'd8, 32'h0000_0002, 4'hF, 3'b001, 1'b0, 5);
      wr("w_d2", 6'd2, 32'h0000_0077, 4'hF, 3'b000, 1'b0, 4);
      @(posedge clk) #1;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = 6'd2;
      PWDATA  = 32'h0000_00EE;
      PSTRB   = 4'hF;
      @(posedge clk) #1;
      PENABLE = 1'b1;
      @(posedge clk) #1;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("abort_no_ready", {31'h0, PREADY}, 32'h0);
      end
      rd("r_d2_abort", 6'd2, 32'h0000_0077, 1'b0, 4);

      // Reset during the second access cycle of a write.
      wr("w_d5", 6'd5, 32'h0000_0099, 4'hF, 3'b000, 1'b0, 4);
      wr("w_wcfg5", 6'd8, 32'h0000_0005, 4'hF, 3'b001, 1'b0, 4);
      @(posedge clk) #1;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = 6'd5;
      PWDATA  = 32'h0000_0055;
      PSTRB   = 4'hF;
      @(posedge clk) #1;
      PENABLE = 1'b1;
      @(posedge clk) #1;
      @(posedge clk) #1;
      PRESET = 1'b1;
      @(negedge clk);
      chk_quiet("rst_mid");
      @(posedge clk) #1;
      PRESET  = 1'b0;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      @(negedge clk);
      chk_quiet("rst_after");
      rd("r_d5_rst", 6'd5, 32'h0, 1'b0, 2);
      rd("r_wcfg_rst", 6'd8, 32'h0, 1'b0, 2);
      rd("r_d3_rst", 6'd3, 32'h0, 1'b0, 2);
      rd("r_id_rst", 6'd9, 32'h0000_00A5, 1'b0, 2);

      repeat (3) @(posedge clk);
      chk("sb_drain", sb.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
